fetch_ctl: RTL and testbench
============================

# fetch_ctl

Instruction-fetch sequencer at the front of the pipeline, directly consuming the `trap_en`/`trap_pc` redirect produced by `system_ctl` in execute, alongside the branch redirect. It generates sequential PCs and drives a single-outstanding req/ack handshake to instruction memory. Fetched words are held in a one-entry output buffer for decode. On a redirect it discards any stale in-flight response and pulses `flush` to the downstream stages.

## Interface
Parameters:
- `RESET_PC`, default 64'h0000_0000_0000_1000: first fetch address after reset.

Ports:
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `trap_en`  in  1  trap/mret redirect from `system_ctl`, one-cycle pulse.
- `trap_pc`  in  `XMSB+1`  trap/mret target.
- `br_en`  in  1  taken branch/jump redirect from execute.
- `br_pc`  in  `XMSB+1`  branch target.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  `XMSB+1`  fetch address; stable while `imem_req` is high.
- `imem_ack`  in  1  response valid; completes the current request.
- `imem_rdata`  in  32  instruction word, valid with `imem_ack`.
- `if_valid`  out  1  instruction available to decode.
- `if_pc`  out  `XMSB+1`  PC of the instruction in `if_inst`.
- `if_inst`  out  32  instruction word.
- `if_ready`  in  1  decode accepts `if_inst` when `if_valid & if_ready`.
- `flush`  out  1  one-cycle pulse; decode/execute invalidate their stages.

## Operation
- Redirect target: `trap_en` has priority over `br_en`. The target's bits [1:0] are forced to 0. A redirect is accepted in every state except reset.
- Next sequential PC: `fetch_pc + 4`, modulo 2^64; wrap-around is silent.
- States:
  - IDLE: no request outstanding.
  - FETCH: `imem_req` is high with `fetch_pc`.
  - DISCARD: the request in flight is stale; `imem_req` stays high with the old address until `imem_ack`.
  - HOLD: the buffer is full and decode has not accepted.
- Transitions:
  - IDLE → FETCH when the buffer is empty or being consumed this cycle.
  - FETCH + ack, no redirect → write the buffer with (`fetch_pc`, `imem_rdata`). Set `fetch_pc += 4`. Go to FETCH if the buffer is freed the same cycle, else HOLD.
  - FETCH + redirect, no ack → DISCARD; latch the target into `pend_pc`.
  - FETCH + ack + redirect in the same cycle → drop the response; `fetch_pc` = target; go to FETCH.
  - DISCARD + ack → `fetch_pc` = `pend_pc`; go to FETCH. A redirect while in DISCARD overwrites `pend_pc`; if it coincides with the ack, the newer target wins.
  - HOLD + `if_ready` → FETCH. HOLD + redirect → clear the buffer; `fetch_pc` = target; go to FETCH.
- Buffer: a redirect in cycle N clears it. `if_valid` is gated low combinationally in cycle N (`valid_q & ~redirect`), so no younger instruction is handed over in the redirect cycle.
- `flush`: asserted in cycle N+1 for each cycle N with a redirect. Back-to-back redirects give back-to-back pulses.
- Reset: all state is cleared, including any request in flight, which is abandoned. Memory must drop any outstanding ack on `rst`.

## Timing
- Reset values: `imem_req`=0, `imem_addr`=`RESET_PC`, `if_valid`=0, `if_pc`=0, `if_inst`=32'h0000_0013 (NOP), `flush`=0, state IDLE, `fetch_pc`=`RESET_PC`.
- Startup: the first cycle after `rst` deasserts enters FETCH; `imem_req`=1 in that cycle's successor.
- Ack in cycle N → `if_valid`=1 in N+1. With `if_ready` held high, the next request issues in N+1 (one word per two cycles with zero-wait memory).
- Redirect with no request outstanding, in cycle N → `imem_req` with the target at N+1.
- Redirect with a request outstanding → the target request issues the cycle after the stale ack.
- `imem_req` never drops before `imem_ack`; `imem_addr` never changes while `imem_req`=1.

## Structure
- `fetch_pkg` (shared): state enum `fetch_state_e` {IDLE, FETCH, DISCARD, HOLD}, `INST_NOP`=32'h0000_0013, `PC_STEP`=4. Width comes from `XMSB`.
- One sub-module, `fetch_buf`: a one-entry PC/instruction holding register with load, consume and clear inputs.
- Redirect arbitration and the state machine stay in `fetch_ctl`.

## Test plan
- Reset, then zero-wait memory with `if_ready`=1 → addresses 0x1000, 0x1004, 0x1008 issued; `if_pc`/`if_inst` match per word; `flush` stays 0.
- Stall: `if_ready`=0 for 5 cycles after the first ack → HOLD; `imem_req`=0; `if_pc`=0x1000 held. Release → the next request is 0x1004.
- `trap_en` with `trap_pc`=0x8000_0003 while a 3-cycle-latency request to 0x1004 is outstanding → 0x1004 stays on the bus until ack; that response is not delivered; `flush` pulses once; the next request is 0x8000_0000.
- `trap_en`=1 and `br_en`=1 in the same cycle (0x2000 vs 0x3000) → the next fetch is 0x2000.
- Redirect to 0x4000 coinciding with `imem_ack` in FETCH → the response is dropped, `if_valid` stays 0, and a request to 0x4000 issues the next cycle.
- `fetch_pc`=0xFFFF_FFFF_FFFF_FFFC, then ack → the next request is 0x0; `rst` asserted mid-request → all outputs take reset values the following cycle.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  localparam int XMSB = 63;

  localparam logic [31:0]   INST_NOP   = 32'h0000_0013;
  localparam logic [XMSB:0] PC_STEP    = 64'd4;
  localparam logic [XMSB:0] ALIGN_MASK = 64'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DISCARD = 2'd2,
    HOLD    = 2'd3
  } fetch_state_e;

  function automatic logic [XMSB:0] align_pc(input logic [XMSB:0] pc);
    return pc & ~ALIGN_MASK;
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// One-entry PC/instruction holding register between fetch and decode.
module fetch_buf
  import fetch_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [XMSB:0] load_pc,
  input  logic [31:0]   load_inst,
  input  logic          consume,
  input  logic          clear,
  output logic          vld_p0,
  output logic [XMSB:0] pc_p0,
  output logic [31:0]   inst_p0
);

  // Stage p0: clear beats load, and a load in the consume cycle refills the entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0  <= 1'b0;
      pc_p0   <= '0;
      inst_p0 <= INST_NOP;
    end else if (clear) begin
      vld_p0 <= 1'b0;
    end else if (load) begin
      vld_p0  <= 1'b1;
      pc_p0   <= load_pc;
      inst_p0 <= load_inst;
    end else if (consume) begin
      vld_p0 <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_ctl.sv
// Fetch sequencer: sequential PC generation, single-outstanding imem handshake,
// trap/branch redirect with stale-response discard and downstream flush.
module fetch_ctl
  import fetch_pkg::*;
#(
  parameter logic [XMSB:0] RESET_PC = 64'h0000_0000_0000_1000
)
(
  input  logic          clk,
  input  logic          rst,
  input  logic          trap_en,
  input  logic [XMSB:0] trap_pc,
  input  logic          br_en,
  input  logic [XMSB:0] br_pc,
  output logic          imem_req,
  output logic [XMSB:0] imem_addr,
  input  logic          imem_ack,
  input  logic [31:0]   imem_rdata,
  output logic          if_valid,
  output logic [XMSB:0] if_pc,
  output logic [31:0]   if_inst,
  input  logic          if_ready,
  output logic          flush
);

  fetch_state_e  state;
  logic [XMSB:0] fetch_pc;
  logic [XMSB:0] pend_pc;

  logic          redirect;
  logic [XMSB:0] redir_pc;
  logic          buf_vld;
  logic          buf_load;
  logic          buf_consume;
  logic          buf_free;
  logic          fetch_on;

  always_comb begin
    redirect = trap_en | br_en;
    redir_pc = align_pc(trap_en ? trap_pc : br_pc);
  end

  // A redirect in this cycle hides the held word so nothing younger slips into decode.
  assign if_valid    = buf_vld & ~redirect;
  assign buf_consume = if_valid & if_ready;
  assign buf_free    = ~buf_vld | buf_consume;
  assign buf_load    = (state == FETCH) & imem_ack & ~redirect;
  // Back-to-back fetch only when decode is taking words; it keeps if_ready for the word it enabled.
  assign fetch_on    = buf_free & if_ready;
  assign imem_addr   = fetch_pc;

  fetch_buf u_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (buf_load),
    .load_pc   (fetch_pc),
    .load_inst (imem_rdata),
    .consume   (buf_consume),
    .clear     (redirect),
    .vld_p0    (buf_vld),
    .pc_p0     (if_pc),
    .inst_p0   (if_inst)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      imem_req <= 1'b0;
      flush    <= 1'b0;
    end else begin
      flush <= redirect;
      unique case (state)
        IDLE: begin
          if (redirect) begin
            fetch_pc <= redir_pc;
            state    <= FETCH;
            imem_req <= 1'b1;
          end else if (buf_free) begin
            state    <= FETCH;
            imem_req <= 1'b1;
          end
        end
        FETCH: begin
          if (imem_ack) begin
            if (redirect) begin
              fetch_pc <= redir_pc;
              state    <= FETCH;
              imem_req <= 1'b1;
            end else begin
              fetch_pc <= fetch_pc + PC_STEP;
              if (fetch_on) begin
                state    <= FETCH;
                imem_req <= 1'b1;
              end else begin
                state    <= HOLD;
                imem_req <= 1'b0;
              end
            end
          end else if (redirect) begin
            // The bus address must stay put until the stale ack; park the target.
            pend_pc <= redir_pc;
            state   <= DISCARD;
          end
        end
        DISCARD: begin
          if (imem_ack) begin
            fetch_pc <= redirect ? redir_pc : pend_pc;
            state    <= FETCH;
            imem_req <= 1'b1;
          end else if (redirect) begin
            pend_pc <= redir_pc;
          end
        end
        HOLD: begin
          if (redirect) begin
            fetch_pc <= redir_pc;
            state    <= FETCH;
            imem_req <= 1'b1;
          end else if (if_ready) begin
            state    <= FETCH;
            imem_req <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctl.sv
// Directed bench for fetch_ctl with a latency-programmable memory responder and
// request/delivery scoreboards.
module tb_fetch_ctl;
  import fetch_pkg::*;

  logic        clk;
  logic        rst;
  logic        trap_en;
  logic [63:0] trap_pc;
  logic        br_en;
  logic [63:0] br_pc;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [63:0] if_pc;
  logic [31:0] if_inst;
  logic        if_ready;
  logic        flush;

  int n_checks = 0;
  int n_fail   = 0;
  int n_flush  = 0;
  int mem_lat  = 1;
  int mem_cnt  = 0;
  bit sb_on    = 0;

  logic [63:0] exp_addr[$];
  logic [63:0] exp_pc[$];

  logic        prev_req;
  logic        prev_ack;
  logic [63:0] prev_addr;

  fetch_ctl #(.RESET_PC(64'h0000_0000_0000_1000)) dut (
    .clk        (clk),
    .rst        (rst),
    .trap_en    (trap_en),
    .trap_pc    (trap_pc),
    .br_en      (br_en),
    .br_pc      (br_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .if_valid   (if_valid),
    .if_pc      (if_pc),
    .if_inst    (if_inst),
    .if_ready   (if_ready),
    .flush      (flush)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] inst_of(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h5A5A_0003;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req"},   imem_req,  64'd0);
    chk({tag, "_addr"},  imem_addr, 64'h1000);
    chk({tag, "_valid"}, if_valid,  64'd0);
    chk({tag, "_pc"},    if_pc,     64'd0);
    chk({tag, "_inst"},  if_inst,   64'h13);
    chk({tag, "_flush"}, flush,     64'd0);
  endtask

  task automatic begin_test(input int lat, input logic rdy);
    sb_on   = 0;
    rst     = 1'b1;
    trap_en = 1'b0;
    br_en   = 1'b0;
    tick();
    tick();
    exp_addr.delete();
    exp_pc.delete();
    n_flush  = 0;
    mem_lat  = lat;
    if_ready = rdy;
    sb_on    = 1;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 80 && exp_pc.size() != 0; i++) tick();
    chk({tag, "_pc_left"},   exp_pc.size(),   64'd0);
    chk({tag, "_addr_left"}, exp_addr.size(), 64'd0);
  endtask

  // Memory: acks after mem_lat cycles of request, drops the ack the cycle after.
  initial begin
    imem_ack   = 1'b0;
    imem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst || imem_ack) begin
        imem_ack = 1'b0;
        mem_cnt  = 0;
      end else if (imem_req) begin
        mem_cnt++;
        if (mem_cnt >= mem_lat) begin
          imem_ack   = 1'b1;
          imem_rdata = inst_of(imem_addr);
        end
      end
    end
  end

  // Scoreboard monitor, sampling on the falling edge.
  initial begin
    logic [63:0] e;
    prev_req  = 1'b0;
    prev_ack  = 1'b0;
    prev_addr = '0;
    forever begin
      @(negedge clk);
      if (flush) n_flush++;
      if (sb_on) begin
        if (imem_req && (!prev_req || prev_ack)) begin
          chk("req_expected", exp_addr.size() > 0, 64'd1);
          if (exp_addr.size() > 0) begin
            e = exp_addr.pop_front();
            chk("req_addr", imem_addr, e);
          end
        end
        if (imem_req && prev_req && !prev_ack) chk("addr_stable", imem_addr, prev_addr);
        if (if_valid && if_ready) begin
          chk("deliver_expected", exp_pc.size() > 0, 64'd1);
          if (exp_pc.size() > 0) begin
            e = exp_pc.pop_front();
            chk("if_pc", if_pc, e);
            chk("if_inst", if_inst, inst_of(e));
          end
        end
      end
      prev_req  = imem_req;
      prev_ack  = imem_ack;
      prev_addr = imem_addr;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; trap_en = 1'b0; trap_pc = '0; br_en = 1'b0; br_pc = '0; if_ready = 1'b1;
    tick(); tick(); tick();
    @(negedge clk);
    chk_reset_vals("reset");

    // Zero-wait streaming.
    begin_test(1, 1'b1);
    exp_addr.push_back(64'h1000); exp_addr.push_back(64'h1004);
    exp_addr.push_back(64'h1008); exp_addr.push_back(64'h100C);
    exp_pc.push_back(64'h1000); exp_pc.push_back(64'h1004); exp_pc.push_back(64'h1008);
    rst = 1'b0;
    drain("stream");
    chk("stream_flush_cnt", n_flush, 64'd0);

    // Decode stall holds the word and stops fetching.
    begin_test(1, 1'b0);
    exp_addr.push_back(64'h1000); exp_addr.push_back(64'h1004); exp_addr.push_back(64'h1008);
    exp_pc.push_back(64'h1000); exp_pc.push_back(64'h1004);
    rst = 1'b0;
    tick(); tick();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall_req", imem_req, 64'd0);
      chk("stall_valid", if_valid, 64'd1);
      chk("stall_pc", if_pc, 64'h1000);
      tick();
    end
    if_ready = 1'b1;
    drain("stall");

    // Trap while a slow request is outstanding.
    begin_test(3, 1'b1);
    exp_addr.push_back(64'h1000); exp_addr.push_back(64'h1004);
    exp_addr.push_back(64'h8000_0000); exp_addr.push_back(64'h8000_0004);
    exp_pc.push_back(64'h1000); exp_pc.push_back(64'h8000_0000);
    rst = 1'b0;
    repeat (5) tick();
    trap_en = 1'b1; trap_pc = 64'h8000_0003;
    tick();
    trap_en = 1'b0;
    @(negedge clk);
    chk("trap_stale_req", imem_req, 64'd1);
    chk("trap_stale_addr", imem_addr, 64'h1004);
    chk("trap_flush", flush, 64'd1);
    drain("trap");
    chk("trap_flush_cnt", n_flush, 64'd1);

    // Trap beats branch in the same cycle.
    begin_test(1, 1'b1);
    exp_addr.push_back(64'h2000); exp_addr.push_back(64'h2004);
    exp_pc.push_back(64'h2000);
    rst = 1'b0;
    trap_en = 1'b1; trap_pc = 64'h2000; br_en = 1'b1; br_pc = 64'h3000;
    tick();
    trap_en = 1'b0; br_en = 1'b0;
    @(negedge clk);
    chk("prio_addr", imem_addr, 64'h2000);
    chk("prio_flush", flush, 64'd1);
    drain("prio");

    // Redirect coincident with ack drops the response.
    begin_test(1, 1'b1);
    exp_addr.push_back(64'h1000); exp_addr.push_back(64'h4000); exp_addr.push_back(64'h4004);
    exp_pc.push_back(64'h4000);
    rst = 1'b0;
    tick();
    br_en = 1'b1; br_pc = 64'h4000;
    @(negedge clk);
    chk("coinc_ack", imem_ack, 64'd1);
    tick();
    br_en = 1'b0;
    @(negedge clk);
    chk("coinc_req", imem_req, 64'd1);
    chk("coinc_addr", imem_addr, 64'h4000);
    chk("coinc_valid", if_valid, 64'd0);
    drain("coinc");

    // Redirect in HOLD clears the buffer and gates if_valid that cycle.
    begin_test(1, 1'b0);
    exp_addr.push_back(64'h1000); exp_addr.push_back(64'h5000); exp_addr.push_back(64'h5004);
    exp_pc.push_back(64'h5000);
    rst = 1'b0;
    tick(); tick(); tick();
    if_ready = 1'b1; br_en = 1'b1; br_pc = 64'h5000;
    @(negedge clk);
    chk("hold_redir_valid", if_valid, 64'd0);
    tick();
    br_en = 1'b0;
    @(negedge clk);
    chk("hold_redir_addr", imem_addr, 64'h5000);
    chk("hold_redir_flush", flush, 64'd1);
    drain("hold_redir");

    // PC wrap, then reset in the middle of a request.
    begin_test(1, 1'b1);
    exp_addr.push_back(64'hFFFF_FFFF_FFFF_FFFC); exp_addr.push_back(64'h0);
    exp_pc.push_back(64'hFFFF_FFFF_FFFF_FFFC);
    rst = 1'b0;
    br_en = 1'b1; br_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    br_en = 1'b0; mem_lat = 4;
    tick();
    @(negedge clk);
    chk("wrap_addr", imem_addr, 64'h0);
    chk("wrap_req", imem_req, 64'd1);
    tick();
    chk("wrap_pc_left", exp_pc.size(), 64'd0);
    chk("wrap_addr_left", exp_addr.size(), 64'd0);
    sb_on = 0;
    rst = 1'b1; br_en = 1'b1; br_pc = 64'h9000;
    @(negedge clk);
    chk("midreq_req", imem_req, 64'd1);
    tick();
    br_en = 1'b0;
    @(negedge clk);
    chk_reset_vals("midreq_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
